// File: rtl/mips_pkg.sv
// Shared definitions for the decode stage: opcode constants, ALUOp codes,
// the control bundle carried into ID/EX, and the bubble constants.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int RA_W     = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic   reg_dst;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   alu_src;
        logic   branch;
        aluop_e alu_op;
    } ctrl_t;

    localparam ctrl_t       CTRL_NOP  = '0;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32-entry register file: two combinational read ports, one write port.
// $0 is hardwired to zero. A write-back in flight this cycle is bypassed to
// the read ports so decode sees the value before it lands in the array.
// Ports: Clk/Rst (sync, active high), we/waddr/wdata write port,
//        raddr1/rdata1 and raddr2/rdata2 read ports.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int RA_W     = mips_pkg::RA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr1,
    input  logic [RA_W-1:0]   raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = (wr_en && waddr == raddr1) ? wdata : regs[raddr1];
        if (raddr2 != '0) rdata2 = (wr_en && waddr == raddr2) ? wdata : regs[raddr2];
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, main decoder, register file read with
// write-back bypass, immediate sign extension, load-use hazard detection and
// the ID/EX register feeding execute.
// Ports: Clk/Rst (sync, active high); IF_* from fetch; Flush/StallIn control;
//        WB_* write-back port; StallOut back to fetch; EX_* ID/EX contents.
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int RA_W     = mips_pkg::RA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] IF_Instr,
    input  logic [DATA_W-1:0] IF_PCPlus4,
    input  logic              IF_Valid,
    input  logic              Flush,
    input  logic              StallIn,
    input  logic              WB_RegWrite,
    input  logic [RA_W-1:0]   WB_WriteReg,
    input  logic [DATA_W-1:0] WB_WriteData,
    output logic              StallOut,
    output logic              EX_Valid,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [RA_W-1:0]   EX_Rs,
    output logic [RA_W-1:0]   EX_Rt,
    output logic [RA_W-1:0]   EX_WriteReg,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemtoReg,
    output logic              EX_ALUSrc,
    output logic              EX_Branch,
    output logic [1:0]        EX_ALUOp,
    output logic [5:0]        EX_Funct
);

    // IF/ID
    logic [DATA_W-1:0] ifid_instr;
    logic [DATA_W-1:0] ifid_pc4;
    logic              ifid_valid;

    // ID/EX control bundle
    ctrl_t ex_ctrl;

    // decode fields
    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs, rt, rd;
    logic [DATA_W-1:0] imm, rdata1, rdata2;
    ctrl_t             ctrl;
    logic              uses_rt;
    logic              hazard;

    assign opcode = ifid_instr[31:26];
    assign rs     = ifid_instr[25:21];
    assign rt     = ifid_instr[20:16];
    assign rd     = ifid_instr[15:11];
    assign imm    = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

    always_comb begin
        ctrl    = CTRL_NOP;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                uses_rt        = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

    // Only compare rt for formats that actually read it; lw/addi use rt as
    // a destination and must not stall on it.
    assign hazard = EX_Valid && ex_ctrl.mem_read && (EX_Rt != '0) && ifid_valid &&
                    ((EX_Rt == rs) || (uses_rt && (EX_Rt == rt)));

    assign StallOut = hazard || StallIn;

    reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RA_W(RA_W)) u_rf (
        .Clk    (Clk),
        .Rst    (Rst),
        .we     (WB_RegWrite),
        .waddr  (WB_WriteReg),
        .wdata  (WB_WriteData),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // IF/ID: flush wins over stall; IF_Valid low captures a clean bubble.
    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            ifid_instr <= INSTR_NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (!StallOut) begin
            ifid_instr <= IF_Valid ? IF_Instr : INSTR_NOP;
            ifid_pc4   <= IF_Valid ? IF_PCPlus4 : '0;
            ifid_valid <= IF_Valid;
        end
    end

    // ID/EX: a stall or an empty IF/ID slot turns into an all-zero bubble.
    always_ff @(posedge Clk) begin
        if (Rst || StallOut || !ifid_valid) begin
            ex_ctrl      <= CTRL_NOP;
            EX_Valid     <= 1'b0;
            EX_PCPlus4   <= '0;
            EX_ReadData1 <= '0;
            EX_ReadData2 <= '0;
            EX_Imm       <= '0;
            EX_Rs        <= '0;
            EX_Rt        <= '0;
            EX_WriteReg  <= '0;
            EX_Funct     <= '0;
        end else begin
            ex_ctrl      <= ctrl;
            EX_Valid     <= 1'b1;
            EX_PCPlus4   <= ifid_pc4;
            EX_ReadData1 <= rdata1;
            EX_ReadData2 <= rdata2;
            EX_Imm       <= imm;
            EX_Rs        <= rs;
            EX_Rt        <= rt;
            EX_WriteReg  <= ctrl.reg_dst ? rd : rt;
            EX_Funct     <= ifid_instr[5:0];
        end
    end

    assign EX_RegWrite = ex_ctrl.reg_write;
    assign EX_MemRead  = ex_ctrl.mem_read;
    assign EX_MemWrite = ex_ctrl.mem_write;
    assign EX_MemtoReg = ex_ctrl.mem_to_reg;
    assign EX_ALUSrc   = ex_ctrl.alu_src;
    assign EX_Branch   = ex_ctrl.branch;
    assign EX_ALUOp    = ex_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, register reads, bypass, $0,
// load-use stall, flush over stall, unknown opcode, beq/sw decode.
module tb_decode_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] IF_Instr, IF_PCPlus4;
    logic        IF_Valid, Flush, StallIn;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        StallOut, EX_Valid;
    logic [31:0] EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_Imm;
    logic [4:0]  EX_Rs, EX_Rt, EX_WriteReg;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_Branch;
    logic [1:0]  EX_ALUOp;
    logic [5:0]  EX_Funct;

    int vectors = 0;
    int errors  = 0;

    always #5 Clk = ~Clk;

    decode_stage dut (
        .Clk(Clk), .Rst(Rst), .IF_Instr(IF_Instr), .IF_PCPlus4(IF_PCPlus4),
        .IF_Valid(IF_Valid), .Flush(Flush), .StallIn(StallIn),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
        .StallOut(StallOut), .EX_Valid(EX_Valid), .EX_PCPlus4(EX_PCPlus4),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WriteReg(EX_WriteReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_Branch(EX_Branch),
        .EX_ALUOp(EX_ALUOp), .EX_Funct(EX_Funct)
    );

    // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]}
    logic [7:0] ctl;
    assign ctl = {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_Branch, EX_ALUOp};

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction enters IF/ID on the first edge and reaches EX on the second.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc4);
        IF_Instr = instr; IF_PCPlus4 = pc4; IF_Valid = 1'b1;
        tick();
        IF_Valid = 1'b0;
        tick();
    endtask

    initial begin
        // reset with garbage on the inputs
        Rst = 1'b1; IF_Instr = 32'h8D09_FFFC; IF_PCPlus4 = 32'hDEAD_BEEF; IF_Valid = 1'b1;
        Flush = 1'b1; StallIn = 1'b0;
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd7; WB_WriteData = 32'hFFFF_FFFF;
        tick(); tick();
        chk("rst_valid", {31'b0, EX_Valid}, 32'd0);
        chk("rst_ctl", {24'b0, ctl}, 32'd0);
        chk("rst_pc4", EX_PCPlus4, 32'd0);
        chk("rst_imm", EX_Imm, 32'd0);
        chk("rst_fields", {17'b0, EX_Rs, EX_Rt, EX_WriteReg}, 32'd0);
        chk("rst_stall", {31'b0, StallOut}, 32'd0);

        Rst = 1'b0; Flush = 1'b0; IF_Valid = 1'b0; WB_RegWrite = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, EX_Valid}, 32'd0);

        // every register reads 0 after reset: add $0,$i,$i
        for (int i = 0; i < 32; i++) begin
            logic [4:0] r;
            r = 5'(i);
            issue({6'b0, r, r, 5'd0, 5'd0, 6'h20}, 32'h100);
            chk($sformatf("rf0_rs_%0d", i), EX_ReadData1, 32'd0);
            chk($sformatf("rf0_rt_%0d", i), EX_ReadData2, 32'd0);
        end

        // preload $18=5, $19=30
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd18; WB_WriteData = 32'd5;
        tick();
        WB_WriteReg = 5'd19; WB_WriteData = 32'd30;
        tick();
        WB_RegWrite = 1'b0;

        // add $17,$18,$19
        issue(32'h0253_8820, 32'h0000_0404);
        chk("add_valid", {31'b0, EX_Valid}, 32'd1);
        chk("add_rd1", EX_ReadData1, 32'd5);
        chk("add_rd2", EX_ReadData2, 32'd30);
        chk("add_wreg", {27'b0, EX_WriteReg}, 32'd17);
        chk("add_ctl", {24'b0, ctl}, 32'b1000_0010);
        chk("add_funct", {26'b0, EX_Funct}, 32'h20);
        chk("add_rs_rt", {22'b0, EX_Rs, EX_Rt}, {22'b0, 5'd18, 5'd19});
        chk("add_pc4", EX_PCPlus4, 32'h0000_0404);

        // bypass: WB writes $18 while the add sits in IF/ID
        IF_Instr = 32'h0253_8820; IF_Valid = 1'b1;
        tick();
        IF_Valid = 1'b0; WB_RegWrite = 1'b1; WB_WriteReg = 5'd18; WB_WriteData = 32'h1234;
        tick();
        WB_RegWrite = 1'b0;
        chk("byp_rd1", EX_ReadData1, 32'h1234);
        chk("byp_rd2", EX_ReadData2, 32'd30);

        // WB to $0 while add $17,$0,$18 is in IF/ID
        IF_Instr = 32'h0012_8820; IF_Valid = 1'b1;
        tick();
        IF_Valid = 1'b0; WB_RegWrite = 1'b1; WB_WriteReg = 5'd0; WB_WriteData = 32'hDEAD;
        tick();
        WB_RegWrite = 1'b0;
        chk("r0_byp", EX_ReadData1, 32'd0);
        chk("r18_kept", EX_ReadData2, 32'h1234);
        issue(32'h0012_8820, 32'h0);
        chk("r0_after", EX_ReadData1, 32'd0);

        // lw $9,-4($8) then dependent add $10,$9,$9
        IF_Instr = 32'h8D09_FFFC; IF_Valid = 1'b1;
        tick();
        chk("lw_nostall", {31'b0, StallOut}, 32'd0);
        IF_Instr = 32'h0129_5020;
        tick();
        chk("lw_imm", EX_Imm, 32'hFFFF_FFFC);
        chk("lw_ctl", {24'b0, ctl}, 32'b1101_1000);
        chk("lw_wreg", {27'b0, EX_WriteReg}, 32'd9);
        chk("lu_stall", {31'b0, StallOut}, 32'd1);
        tick();
        chk("lu_bubble", {31'b0, EX_Valid}, 32'd0);
        chk("lu_bubble_ctl", {24'b0, ctl}, 32'd0);
        chk("lu_stall_drop", {31'b0, StallOut}, 32'd0);
        IF_Valid = 1'b0;
        tick();
        chk("lu_add_valid", {31'b0, EX_Valid}, 32'd1);
        chk("lu_add_wreg", {27'b0, EX_WriteReg}, 32'd10);
        chk("lu_add_rs_rt", {22'b0, EX_Rs, EX_Rt}, {22'b0, 5'd9, 5'd9});
        chk("lu_add_ctl", {24'b0, ctl}, 32'b1000_0010);

        // Flush + StallIn together with a lw in IF/ID
        IF_Instr = 32'h8D09_FFFC; IF_Valid = 1'b1;
        tick();
        IF_Instr = 32'h0129_5020; Flush = 1'b1; StallIn = 1'b1;
        #1;
        chk("fl_stallout", {31'b0, StallOut}, 32'd1);
        tick();
        Flush = 1'b0; StallIn = 1'b0;
        #1;
        chk("fl_ex_bubble", {31'b0, EX_Valid}, 32'd0);
        chk("fl_no_hazard", {31'b0, StallOut}, 32'd0);
        tick();
        chk("fl_ex_bubble2", {31'b0, EX_Valid}, 32'd0);
        chk("fl_no_hazard2", {31'b0, StallOut}, 32'd0);
        IF_Valid = 1'b0;
        tick();
        chk("fl_add_issues", {31'b0, EX_Valid}, 32'd1);

        // unknown opcode
        issue(32'hFC00_0000, 32'h0);
        chk("unk_valid", {31'b0, EX_Valid}, 32'd1);
        chk("unk_ctl", {24'b0, ctl}, 32'd0);

        // beq $8,$9,-1 and sw $9,8($8)
        issue(32'h1109_FFFF, 32'h0);
        chk("beq_ctl", {24'b0, ctl}, 32'b0000_0101);
        issue(32'hAD09_0008, 32'h0);
        chk("sw_ctl", {24'b0, ctl}, 32'b0010_1000);
        chk("sw_imm", EX_Imm, 32'd8);

        // reset mid-stream discards the in-flight instruction
        IF_Instr = 32'h0253_8820; IF_Valid = 1'b1;
        tick();
        Rst = 1'b1; IF_Valid = 1'b0;
        tick();
        chk("midrst_valid", {31'b0, EX_Valid}, 32'd0);
        Rst = 1'b0;
        tick();
        chk("midrst_drop", {31'b0, EX_Valid}, 32'd0);
        issue(32'h0253_8820, 32'h0);
        chk("midrst_rf_clr", EX_ReadData1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage.
- Registers the fetched instruction and its PC+4 in an IF/ID register, then decodes it.
- Reads the 32x32 register file, with write-back bypass, and sign-extends the immediate.
- Detects load-use hazards and drives the ID/EX pipeline register consumed by the execute stage.

Parameters:
- DATA_W, 32, datapath/instruction width
- NUM_REGS, 32, register file depth
- RA_W, 5, register address width

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- IF_Instr  in  32  instruction from fetch memory (already registered by fetch)
- IF_PCPlus4  in  32  PC+4 aligned with IF_Instr
- IF_Valid  in  1  IF_Instr carries a real instruction
- Flush  in  1  kill the instruction entering IF/ID (taken branch)
- StallIn  in  1  external stall request
- WB_RegWrite  in  1  write-back enable
- WB_WriteReg  in  5  write-back destination
- WB_WriteData  in  32  write-back data
- StallOut  out  1  hold request to fetch PC and instruction memory (combinational)
- EX_Valid  out  1  ID/EX holds a real instruction
- EX_PCPlus4  out  32  ID/EX PC+4
- EX_ReadData1  out  32  rs value
- EX_ReadData2  out  32  rt value
- EX_Imm  out  32  sign-extended imm16
- EX_Rs, EX_Rt, EX_WriteReg  out  5 each  forwarding and destination fields
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_Branch  out  1 each  control bits
- EX_ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
- EX_Funct  out  6  instr[5:0]

Behaviour:
- Reset, synchronous: IF/ID cleared (instr 0, pc4 0, valid 0); all EX_* outputs 0; all 32 registers 0. Reset asserted mid-stream discards everything in flight. The first instruction is accepted on the edge after Rst deasserts.
- Latency: instruction accepted at edge n appears on EX_* after edge n+1.
- Decode from the IF/ID copy:
  - R-type op 000000: RegDst, RegWrite, ALUOp=10.
  - lw 100011: ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=00.
  - sw 101011: ALUSrc, MemWrite, ALUOp=00.
  - beq 000100: Branch, ALUOp=01.
  - addi 001000: ALUSrc, RegWrite, ALUOp=00.
  - Any other opcode: all control 0, EX_Valid still follows IF/ID valid.
  - Instruction word 0 (sll $0) decodes as R-type writing $0; this is harmless.
- EX_WriteReg = RegDst ? rd : rt. EX_Imm = {16{instr[15]}, instr[15:0]}.
- Register file:
  - Writes on the rising edge when WB_RegWrite is set and WB_WriteReg != 0.
  - $0 always reads 0; writes to it are ignored.
  - Reads are combinational with bypass: if WB_RegWrite, WB_WriteReg != 0 and WB_WriteReg matches rs/rt in the same cycle, the read returns WB_WriteData.
- Load-use hazard:
  - Asserted when EX_Valid & EX_MemRead & EX_Rt != 0 & (EX_Rt == rs or EX_Rt == rt of a valid IF/ID instruction).
  - The rt compare applies only for R-type, sw and beq.
- StallOut = hazard | StallIn.
- While StallOut is high: IF/ID holds its contents; ID/EX loads a bubble (all control 0, EX_Valid 0, data fields don't-care but driven 0).
- Flush: IF/ID loads a bubble on the edge. Flush beats a stall on IF/ID. A hazard computed on a flushed slot is masked next cycle because IF/ID valid = 0.
- IF_Valid = 0: IF/ID captures a bubble unless stalled.
- Fetch holds its PC and memory address while StallOut is high. Fetch owns that hookup; this block asserts nothing further.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI)
  - ALUOp encodings
  - control-bundle struct/field widths
  - NOP/bubble constant
- One sub-module: reg_file (2 read ports, 1 write port, $0 hardwired, bypass).
- Decode logic, hazard unit and both pipeline registers stay in decode_stage.

Test Plan:
- Reset with garbage on inputs -> all EX_* 0, StallOut 0; read of every register returns 0.
- Preload $18=5, $19=30 via WB; feed 0x02538820 (add $17,$18,$19) -> two edges later EX_ReadData1=5, EX_ReadData2=30, EX_WriteReg=17, RegWrite=1, ALUOp=10, EX_Funct=0x20.
- WB writes $18=0x1234 in the same cycle the add is in IF/ID -> EX_ReadData1=0x1234 (bypass). WB to $0 -> $0 still reads 0.
- lw $9,-4($8) (0x8D09FFFC) then add $10,$9,$9:
  - lw produces EX_Imm=0xFFFFFFFC, MemRead=1.
  - StallOut=1 for exactly one cycle; one bubble (EX_Valid=0) is inserted.
  - The add then issues unchanged.
- Flush with StallIn both high for one cycle -> IF/ID becomes bubble; the next EX is a bubble; no spurious hazard follows.
- Unknown opcode 0xFC000000 with IF_Valid=1 -> EX_Valid=1, all control 0.
